// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - two-stage register-file/ALU datapath with valid/ready handshakes and operand bypass
// Optional macro ZERO_REG_EN: register 0 reads as zero and ignores writes.
module pipelined_datapath #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic [ADDR_W-1:0] RegReadAddr1,
    input  logic [ADDR_W-1:0] RegReadAddr2,
    input  logic [ADDR_W-1:0] RegWriteAddr,
    input  logic              RegWriteEnable,
    input  logic [2:0]        ALUControl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [WIDTH-1:0]  OutResult,
    output logic              OutOverflow,
    output logic              OutZero
);
    localparam int NREG = 1 << ADDR_W;
    localparam int SHW  = $clog2(WIDTH);

    logic [WIDTH-1:0]  rf_q [NREG];

    logic              e_valid_q, e_valid_d;
    logic [WIDTH-1:0]  e_a_q, e_a_d, e_b_q, e_b_d;
    logic [2:0]        e_op_q, e_op_d;
    logic [ADDR_W-1:0] e_waddr_q, e_waddr_d;
    logic              e_we_q, e_we_d;

    logic              w_valid_q, w_valid_d;
    logic [WIDTH-1:0]  w_result_q, w_result_d;
    logic              w_ovf_q, w_ovf_d;
    logic              w_zero_q, w_zero_d;

    logic              w_move, e_move, accept, rf_wen;
    logic [WIDTH-1:0]  alu_res, op_a, op_b;
    logic              alu_ovf;

    always_comb begin
        w_move  = w_valid_q && OutReady;
        e_move  = e_valid_q && (!w_valid_q || w_move);
        InReady = Rst && (!e_valid_q || e_move);
        accept  = InValid && InReady;
`ifdef ZERO_REG_EN
        rf_wen  = e_move && e_we_q && (e_waddr_q != '0);
`else
        rf_wen  = e_move && e_we_q;
`endif
    end

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (e_op_q)
            3'b000: begin
                alu_res = e_a_q + e_b_q;
                alu_ovf = (e_a_q[WIDTH-1] == e_b_q[WIDTH-1]) && (alu_res[WIDTH-1] != e_a_q[WIDTH-1]);
            end
            3'b001: begin
                alu_res = e_a_q - e_b_q;
                alu_ovf = (e_a_q[WIDTH-1] != e_b_q[WIDTH-1]) && (alu_res[WIDTH-1] != e_a_q[WIDTH-1]);
            end
            3'b010: alu_res = e_a_q & e_b_q;
            3'b011: alu_res = e_a_q | e_b_q;
            3'b100: alu_res = e_a_q ^ e_b_q;
            3'b101: alu_res[0] = $signed(e_a_q) < $signed(e_b_q);
            3'b110: alu_res = e_a_q << e_b_q[SHW-1:0];
            default: alu_res = e_a_q >> e_b_q[SHW-1:0];
        endcase
    end

    // The result leaving E this cycle is not in the register file yet, so forward it.
    always_comb begin
        op_a = rf_q[RegReadAddr1];
        op_b = rf_q[RegReadAddr2];
`ifdef ZERO_REG_EN
        if (RegReadAddr1 == '0) op_a = '0;
        if (RegReadAddr2 == '0) op_b = '0;
`endif
        if (rf_wen && (e_waddr_q == RegReadAddr1)) op_a = alu_res;
        if (rf_wen && (e_waddr_q == RegReadAddr2)) op_b = alu_res;
    end

    always_comb begin
        e_valid_d  = e_valid_q;
        e_a_d      = e_a_q;
        e_b_d      = e_b_q;
        e_op_d     = e_op_q;
        e_waddr_d  = e_waddr_q;
        e_we_d     = e_we_q;
        w_valid_d  = w_valid_q;
        w_result_d = w_result_q;
        w_ovf_d    = w_ovf_q;
        w_zero_d   = w_zero_q;
        if (accept) begin
            e_valid_d = 1'b1;
            e_a_d     = op_a;
            e_b_d     = op_b;
            e_op_d    = ALUControl;
            e_waddr_d = RegWriteAddr;
            e_we_d    = RegWriteEnable;
        end else if (e_move) begin
            e_valid_d = 1'b0;
        end
        if (e_move) begin
            w_valid_d  = 1'b1;
            w_result_d = alu_res;
            w_ovf_d    = alu_ovf;
            w_zero_d   = (alu_res == '0);
        end else if (w_move) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            e_valid_q  <= 1'b0;
            e_a_q      <= '0;
            e_b_q      <= '0;
            e_op_q     <= '0;
            e_waddr_q  <= '0;
            e_we_q     <= 1'b0;
            w_valid_q  <= 1'b0;
            w_result_q <= '0;
            w_ovf_q    <= 1'b0;
            w_zero_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            e_valid_q  <= e_valid_d;
            e_a_q      <= e_a_d;
            e_b_q      <= e_b_d;
            e_op_q     <= e_op_d;
            e_waddr_q  <= e_waddr_d;
            e_we_q     <= e_we_d;
            w_valid_q  <= w_valid_d;
            w_result_q <= w_result_d;
            w_ovf_q    <= w_ovf_d;
            w_zero_q   <= w_zero_d;
            if (rf_wen) rf_q[e_waddr_q] <= alu_res;
        end
    end

    assign OutValid    = w_valid_q;
    assign OutResult   = w_result_q;
    assign OutOverflow = w_ovf_q;
    assign OutZero     = w_zero_q;
endmodule

// File: tb/tb_pipelined_datapath.sv
// tb/tb_pipelined_datapath.sv - directed self-checking bench for pipelined_datapath
module tb_pipelined_datapath;
    logic        Clk;
    logic        Rst;
    logic        InValid;
    logic        InReady;
    logic [2:0]  RegReadAddr1, RegReadAddr2, RegWriteAddr;
    logic        RegWriteEnable;
    logic [2:0]  ALUControl;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutResult;
    logic        OutOverflow;
    logic        OutZero;

    int tests = 0;
    int fails = 0;

    pipelined_datapath #(.WIDTH(32), .ADDR_W(3)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .RegReadAddr1(RegReadAddr1), .RegReadAddr2(RegReadAddr2),
        .RegWriteAddr(RegWriteAddr), .RegWriteEnable(RegWriteEnable),
        .ALUControl(ALUControl), .OutValid(OutValid), .OutReady(OutReady),
        .OutResult(OutResult), .OutOverflow(OutOverflow), .OutZero(OutZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] wa,
                         input logic we, input logic [2:0] op);
        InValid        = 1'b1;
        RegReadAddr1   = a1;
        RegReadAddr2   = a2;
        RegWriteAddr   = wa;
        RegWriteEnable = we;
        ALUControl     = op;
    endtask

    typedef struct {
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [2:0]  op;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        Rst = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        RegReadAddr1 = '0; RegReadAddr2 = '0; RegWriteAddr = '0;
        RegWriteEnable = 1'b0; ALUControl = '0;

        step(); step();
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rst_inready", {31'd0, InReady}, 32'd0);
        chk("rst_result", OutResult, 32'd0);
        chk("rst_zero", {31'd0, OutZero}, 32'd0);
        chk("rst_ovf", {31'd0, OutOverflow}, 32'd0);
        chk("rst_r3", dut.rf_q[3], 32'd0);

        Rst = 1'b1;
        #1;
        chk("inready_after_rst", {31'd0, InReady}, 32'd1);
        dut.rf_q[1] = 32'd5;
        dut.rf_q[2] = 32'd3;

        // ADD R3=R1+R2 followed immediately by dependent SUB R4=R3-R1
        issue(3'd1, 3'd2, 3'd3, 1'b1, 3'b000);
        step();
        chk("b2b_inready", {31'd0, InReady}, 32'd1);
        issue(3'd3, 3'd1, 3'd4, 1'b1, 3'b001);
        step();
        chk("add_valid", {31'd0, OutValid}, 32'd1);
        chk("add_result", OutResult, 32'd8);
        chk("add_zero", {31'd0, OutZero}, 32'd0);
        chk("add_ovf", {31'd0, OutOverflow}, 32'd0);
        chk("add_r3", dut.rf_q[3], 32'd8);
        InValid = 1'b0;
        step();
        chk("bypass_valid", {31'd0, OutValid}, 32'd1);
        chk("bypass_result", OutResult, 32'd3);
        chk("bypass_r4", dut.rf_q[4], 32'd3);
        step();
        chk("drain_valid", {31'd0, OutValid}, 32'd0);

        // signed overflow on ADD, then zero flag from SUB of equal values
        dut.rf_q[5] = 32'h7FFF_FFFF;
        dut.rf_q[6] = 32'd1;
        issue(3'd5, 3'd6, 3'd7, 1'b1, 3'b000);
        step();
        issue(3'd2, 3'd2, 3'd0, 1'b0, 3'b001);
        step();
        chk("ovf_result", OutResult, 32'h8000_0000);
        chk("ovf_flag", {31'd0, OutOverflow}, 32'd1);
        chk("ovf_zero", {31'd0, OutZero}, 32'd0);
        InValid = 1'b0;
        step();
        chk("sub_eq_result", OutResult, 32'd0);
        chk("sub_eq_zero", {31'd0, OutZero}, 32'd1);
        chk("sub_eq_ovf", {31'd0, OutOverflow}, 32'd0);
        chk("ovf_r7", dut.rf_q[7], 32'h8000_0000);
        step();

        // R1=5 R2=3 R5=7FFFFFFF R6=1 R7=80000000, back-to-back, no writes
        vecs[0] = '{3'd1, 3'd2, 3'b010, 32'd1, 1'b0};
        vecs[1] = '{3'd1, 3'd2, 3'b011, 32'd7, 1'b0};
        vecs[2] = '{3'd1, 3'd2, 3'b100, 32'd6, 1'b0};
        vecs[3] = '{3'd5, 3'd7, 3'b101, 32'd0, 1'b0};
        vecs[4] = '{3'd7, 3'd5, 3'b101, 32'd1, 1'b0};
        vecs[5] = '{3'd1, 3'd2, 3'b110, 32'd40, 1'b0};
        vecs[6] = '{3'd1, 3'd5, 3'b110, 32'h8000_0000, 1'b0};
        vecs[7] = '{3'd7, 3'd6, 3'b111, 32'h4000_0000, 1'b0};
        vecs[8] = '{3'd7, 3'd6, 3'b001, 32'h7FFF_FFFF, 1'b1};
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) issue(vecs[i].a1, vecs[i].a2, 3'd0, 1'b0, vecs[i].op);
            else InValid = 1'b0;
            step();
            if (i > 0) begin
                chk($sformatf("vec%0d_valid", i - 1), {31'd0, OutValid}, 32'd1);
                chk($sformatf("vec%0d_result", i - 1), OutResult, vecs[i-1].res);
                chk($sformatf("vec%0d_ovf", i - 1), {31'd0, OutOverflow}, {31'd0, vecs[i-1].ovf});
            end
        end
        step();

        // backpressure: two accepts, then stall with result held
        OutReady = 1'b0;
        issue(3'd1, 3'd2, 3'd4, 1'b1, 3'b000);
        step();
        chk("bp_inready1", {31'd0, InReady}, 32'd1);
        issue(3'd1, 3'd2, 3'd4, 1'b1, 3'b001);
        step();
        chk("bp_valid", {31'd0, OutValid}, 32'd1);
        chk("bp_result_a", OutResult, 32'd8);
        chk("bp_inready_low", {31'd0, InReady}, 32'd0);
        chk("bp_r4_first", dut.rf_q[4], 32'd8);
        issue(3'd1, 3'd2, 3'd6, 1'b1, 3'b011);
        step();
        chk("bp_hold1", OutResult, 32'd8);
        chk("bp_inready_hold", {31'd0, InReady}, 32'd0);
        chk("bp_r6_untouched", dut.rf_q[6], 32'd1);
        step();
        chk("bp_hold2", OutResult, 32'd8);
        chk("bp_r4_hold", dut.rf_q[4], 32'd8);
        OutReady = 1'b1;
        #1;
        chk("bp_release_inready", {31'd0, InReady}, 32'd1);
        step();
        chk("bp_result_b", OutResult, 32'd2);
        chk("bp_r4_second", dut.rf_q[4], 32'd2);
        InValid = 1'b0;
        step();
        chk("bp_result_c", OutResult, 32'd7);
        chk("bp_r6", dut.rf_q[6], 32'd7);
        step();
        chk("bp_drained", {31'd0, OutValid}, 32'd0);

        // reset with both stages full
        OutReady = 1'b0;
        issue(3'd1, 3'd1, 3'd2, 1'b1, 3'b000);
        step();
        issue(3'd1, 3'd1, 3'd3, 1'b1, 3'b000);
        step();
        chk("full_inready", {31'd0, InReady}, 32'd0);
        chk("full_r3_preissue", dut.rf_q[3], 32'd8);
        Rst = 1'b0;
        step();
        chk("midrst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("midrst_inready", {31'd0, InReady}, 32'd0);
        chk("midrst_result", OutResult, 32'd0);
        chk("midrst_r3", dut.rf_q[3], 32'd0);
        InValid = 1'b0;
        OutReady = 1'b1;
        Rst = 1'b1;
        step(); step();
        chk("postrst_idle", {31'd0, OutValid}, 32'd0);

        // register 0 behaviour
        dut.rf_q[1] = 32'd5;
        dut.rf_q[2] = 32'd3;
        issue(3'd1, 3'd2, 3'd0, 1'b1, 3'b000);
        step();
        issue(3'd0, 3'd1, 3'd5, 1'b1, 3'b000);
        step();
        chk("r0_first", OutResult, 32'd8);
        InValid = 1'b0;
        step();
`ifdef ZERO_REG_EN
        chk("r0_second", OutResult, 32'd5);
        chk("r0_r5", dut.rf_q[5], 32'd5);
        chk("r0_value", dut.rf_q[0], 32'd0);
`else
        chk("r0_second", OutResult, 32'd13);
        chk("r0_r5", dut.rf_q[5], 32'd13);
        chk("r0_value", dut.rf_q[0], 32'd8);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
